// File: rtl/fight_controller.sv
// fight_controller: two-player side-view fighting game logic.
// Every state change happens on the clock edge at which frame_tick is high.
// P1 moves first. P2 then moves against P1's new position, so the two
// bodies never overlap. Attacks, hits, health and the game-over decision
// follow from those positions.
//
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   frame_tick                one-cycle pulse per video frame
//   p1_left/right/attack      P1 level buttons
//   p2_left/right/attack      P2 level buttons
//   p1_x, p2_x                player left-edge x (registered)
//   p1_y, p2_y                player top y, fixed at GROUND_Y (registered)
//   p1_state, p2_state        0=IDLE 1=MOVE 2=ATTACK 3=HIT (registered)
//   p1_health, p2_health      remaining health (registered)
//   game_over, winner         end flag; winner 01=P1 10=P2 11=draw (registered)
//
// Build option: define FIGHT_KNOCKBACK_EN to push a hit victim STEP*4
// pixels away from the attacker.
module fight_controller #(
   parameter int SCREEN_W      = 640,
   parameter int PLAYER_W      = 50,
   parameter int STEP          = 4,
   parameter int REACH         = 20,
   parameter int ATTACK_FRAMES = 8,
   parameter int HIT_FRAMES    = 16,
   parameter int START_HEALTH  = 10,
   parameter int P1_START_X    = 20,
   parameter int P2_START_X    = 570,
   parameter int GROUND_Y      = 380
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       p1_left,
   input  logic       p1_right,
   input  logic       p1_attack,
   input  logic       p2_left,
   input  logic       p2_right,
   input  logic       p2_attack,
   output logic [9:0] p1_x,
   output logic [9:0] p2_x,
   output logic [9:0] p1_y,
   output logic [9:0] p2_y,
   output logic [1:0] p1_state,
   output logic [1:0] p2_state,
   output logic [3:0] p1_health,
   output logic [3:0] p2_health,
   output logic       game_over,
   output logic [1:0] winner
);

   localparam int unsigned X_W     = 10;
   localparam int unsigned HP_W    = 4;
   localparam int          CNT_MAX = (ATTACK_FRAMES > HIT_FRAMES) ? ATTACK_FRAMES : HIT_FRAMES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int          X_MAX   = SCREEN_W - PLAYER_W;
`ifdef FIGHT_KNOCKBACK_EN
   localparam int          KNOCK   = STEP * 4;
`endif

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MOVE   = 2'd1,
      ST_ATTACK = 2'd2,
      ST_HIT    = 2'd3
   } pstate_t;

   pstate_t          p1_st_q, p2_st_q, p1_st_d, p2_st_d;
   logic [CNT_W-1:0] p1_cnt_q, p2_cnt_q, p1_cnt_d, p2_cnt_d;
   logic [X_W-1:0]   p1_x_d, p2_x_d;
   logic [HP_W-1:0]  p1_hp_d, p2_hp_d;
   logic             over_d;
   logic [1:0]       winner_d;
   logic             upd;
   logic             p1_enter, p2_enter, hit_p1, hit_p2;
   int               p1_xn, p2_xn, gap;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Once the game is over, frame ticks are ignored until reset.
   assign upd      = frame_tick & ~game_over;
   assign p1_state = p1_st_q;
   assign p2_state = p2_st_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         p1_st_q   <= ST_IDLE;
         p2_st_q   <= ST_IDLE;
         p1_cnt_q  <= '0;
         p2_cnt_q  <= '0;
         p1_x      <= X_W'(P1_START_X);
         p2_x      <= X_W'(P2_START_X);
         p1_y      <= X_W'(GROUND_Y);
         p2_y      <= X_W'(GROUND_Y);
         p1_health <= HP_W'(START_HEALTH);
         p2_health <= HP_W'(START_HEALTH);
         game_over <= 1'b0;
         winner    <= 2'b00;
      end else if (upd) begin
         p1_st_q   <= p1_st_d;
         p2_st_q   <= p2_st_d;
         p1_cnt_q  <= p1_cnt_d;
         p2_cnt_q  <= p2_cnt_d;
         p1_x      <= p1_x_d;
         p2_x      <= p2_x_d;
         p1_health <= p1_hp_d;
         p2_health <= p2_hp_d;
         game_over <= over_d;
         winner    <= winner_d;
      end
   end

   // Next-state logic for one frame update
   always_comb begin
      p1_st_d  = p1_st_q;
      p2_st_d  = p2_st_q;
      p1_cnt_d = p1_cnt_q;
      p2_cnt_d = p2_cnt_q;
      p1_hp_d  = p1_health;
      p2_hp_d  = p2_health;
      p1_enter = 1'b0;
      p2_enter = 1'b0;
      hit_p1   = 1'b0;
      hit_p2   = 1'b0;
      p1_xn    = int'(p1_x);
      p2_xn    = int'(p2_x);
      gap      = 0;

      // P1 first. Moving right, it stops at P2's current left edge.
      case (p1_st_q)
         ST_IDLE, ST_MOVE: begin
            if (p1_attack) begin
               p1_st_d  = ST_ATTACK;
               p1_cnt_d = CNT_W'(ATTACK_FRAMES - 1);
               p1_enter = 1'b1;
            end else if (p1_left ^ p1_right) begin
               p1_st_d = ST_MOVE;
               if (p1_left) p1_xn = imax(p1_xn - STEP, 0);
               else         p1_xn = imin(imin(p1_xn + STEP, X_MAX), int'(p2_x) - PLAYER_W);
            end else begin
               p1_st_d = ST_IDLE;
            end
         end
         default: begin
            if (p1_cnt_q == '0) p1_st_d  = ST_IDLE;
            else                p1_cnt_d = p1_cnt_q - 1'b1;
         end
      endcase

      // P2 next. Moving left, it stops at P1's updated right edge.
      case (p2_st_q)
         ST_IDLE, ST_MOVE: begin
            if (p2_attack) begin
               p2_st_d  = ST_ATTACK;
               p2_cnt_d = CNT_W'(ATTACK_FRAMES - 1);
               p2_enter = 1'b1;
            end else if (p2_left ^ p2_right) begin
               p2_st_d = ST_MOVE;
               if (p2_left) p2_xn = imax(imax(p2_xn - STEP, 0), p1_xn + PLAYER_W);
               else         p2_xn = imin(p2_xn + STEP, X_MAX);
            end else begin
               p2_st_d = ST_IDLE;
            end
         end
         default: begin
            if (p2_cnt_q == '0) p2_st_d  = ST_IDLE;
            else                p2_cnt_d = p2_cnt_q - 1'b1;
         end
      endcase

      // Hits are tested only when an attack starts, using post-move positions.
      // A player already in HIT cannot be hit again.
      gap    = p2_xn - (p1_xn + PLAYER_W);
      hit_p2 = p1_enter && (gap <= REACH) && (p2_st_q != ST_HIT);
      hit_p1 = p2_enter && (gap <= REACH) && (p1_st_q != ST_HIT);

      if (hit_p1) begin
         p1_st_d  = ST_HIT;
         p1_cnt_d = CNT_W'(HIT_FRAMES - 1);
         p1_hp_d  = (p1_health == '0) ? '0 : p1_health - 1'b1;
`ifdef FIGHT_KNOCKBACK_EN
         p1_xn    = imax(p1_xn - KNOCK, 0);
`endif
      end
      if (hit_p2) begin
         p2_st_d  = ST_HIT;
         p2_cnt_d = CNT_W'(HIT_FRAMES - 1);
         p2_hp_d  = (p2_health == '0) ? '0 : p2_health - 1'b1;
`ifdef FIGHT_KNOCKBACK_EN
         p2_xn    = imin(p2_xn + KNOCK, X_MAX);
`endif
      end

      p1_x_d = X_W'(p1_xn);
      p2_x_d = X_W'(p2_xn);

      // winner bit1 = P1 out, bit0 = P2 out: 01 P1 wins, 10 P2 wins, 11 draw
      winner_d = {p1_hp_d == '0, p2_hp_d == '0};
      over_d   = |winner_d;
   end

endmodule

// File: tb/tb_fight_controller.sv
// Directed testbench for fight_controller with default parameters.
// The hit test starts with a gap of 8 px between the players.
module tb_fight_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       frame_tick;
   logic       p1_left, p1_right, p1_attack, p2_left, p2_right, p2_attack;
   logic [9:0] p1_x, p2_x, p1_y, p2_y;
   logic [1:0] p1_state, p2_state;
   logic [3:0] p1_health, p2_health;
   logic       game_over;
   logic [1:0] winner;

   int checks = 0;
   int errors = 0;

`ifdef FIGHT_KNOCKBACK_EN
   localparam int KB = 16;
`else
   localparam int KB = 0;
`endif

   fight_controller dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick),
      .p1_left(p1_left), .p1_right(p1_right), .p1_attack(p1_attack),
      .p2_left(p2_left), .p2_right(p2_right), .p2_attack(p2_attack),
      .p1_x(p1_x), .p2_x(p2_x), .p1_y(p1_y), .p2_y(p2_y),
      .p1_state(p1_state), .p2_state(p2_state),
      .p1_health(p1_health), .p2_health(p2_health),
      .game_over(game_over), .winner(winner)
   );

   always #5 clk = ~clk;

   task automatic btn(input logic l1, r1, a1, l2, r2, a2);
      p1_left = l1; p1_right = r1; p1_attack = a1;
      p2_left = l2; p2_right = r2; p2_attack = a2;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         @(posedge clk);
         #1;
         frame_tick = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Bring the players to p1_x=260, p2_x=330, a gap of 20 px.
   task automatic approach();
      do_reset();
      btn(0, 1, 0, 1, 0, 0);
      tick(60);
      btn(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      // Reset wins over a coincident frame_tick and held buttons.
      btn(0, 1, 1, 1, 0, 1);
      frame_tick = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      frame_tick = 1'b0;
      btn(0, 0, 0, 0, 0, 0);
      checks++; if (p1_x !== 10'd20) begin errors++; $display("FAIL reset_p1_x: got %0d expected 20", p1_x); end
      checks++; if (p2_x !== 10'd570) begin errors++; $display("FAIL reset_p2_x: got %0d expected 570", p2_x); end
      checks++; if (p1_y !== 10'd380 || p2_y !== 10'd380) begin errors++; $display("FAIL reset_y: got %0d/%0d expected 380/380", p1_y, p2_y); end
      checks++; if (p1_state !== 2'd0 || p2_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d/%0d expected 0/0", p1_state, p2_state); end
      checks++; if (p1_health !== 4'd10 || p2_health !== 4'd10) begin errors++; $display("FAIL reset_health: got %0d/%0d expected 10/10", p1_health, p2_health); end
      checks++; if (game_over !== 1'b0 || winner !== 2'b00) begin errors++; $display("FAIL reset_over: got %0d/%0d expected 0/0", game_over, winner); end
   endtask

   task automatic test_move_right();
      do_reset();
      btn(0, 1, 0, 0, 0, 0);
      tick(3);
      checks++; if (p1_x !== 10'd32) begin errors++; $display("FAIL move_p1_x: got %0d expected 32", p1_x); end
      checks++; if (p1_state !== 2'd1) begin errors++; $display("FAIL move_p1_state: got %0d expected 1", p1_state); end
      checks++; if (p2_x !== 10'd570 || p2_state !== 2'd0) begin errors++; $display("FAIL move_p2: got x=%0d st=%0d expected 570/0", p2_x, p2_state); end
      // Without frame_tick nothing moves.
      repeat (5) @(posedge clk);
      #1;
      checks++; if (p1_x !== 10'd32) begin errors++; $display("FAIL no_tick_p1_x: got %0d expected 32", p1_x); end
      btn(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_clamp_left();
      do_reset();
      btn(1, 0, 0, 0, 0, 0);
      tick(10);
      checks++; if (p1_x !== 10'd0) begin errors++; $display("FAIL clamp_p1_x: got %0d expected 0", p1_x); end
      checks++; if (p1_state !== 2'd1) begin errors++; $display("FAIL clamp_p1_state: got %0d expected 1", p1_state); end
      btn(1, 1, 0, 0, 0, 0);
      tick(1);
      checks++; if (p1_state !== 2'd0 || p1_x !== 10'd0) begin errors++; $display("FAIL both_dir: got st=%0d x=%0d expected 0/0", p1_state, p1_x); end
      btn(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_block();
      do_reset();
      btn(0, 1, 0, 1, 0, 0);
      tick(5);
      checks++; if (p1_x !== 10'd40 || p2_x !== 10'd550) begin errors++; $display("FAIL walk_in: got %0d/%0d expected 40/550", p1_x, p2_x); end
      btn(0, 1, 0, 0, 0, 0);
      tick(115);
      checks++; if (p1_x !== 10'd500) begin errors++; $display("FAIL contact_p1_x: got %0d expected 500", p1_x); end
      btn(0, 1, 0, 1, 0, 0);
      tick(1);
      checks++; if (p1_x !== 10'd500 || p2_x !== 10'd550) begin errors++; $display("FAIL block_x: got %0d/%0d expected 500/550", p1_x, p2_x); end
      checks++; if (p1_state !== 2'd1 || p2_state !== 2'd1) begin errors++; $display("FAIL block_state: got %0d/%0d expected 1/1", p1_state, p2_state); end
      btn(0, 0, 0, 0, 0, 0);
   endtask

   // Continues from test_block: p1_x=500, p2_x=550.
   task automatic test_hit();
      btn(0, 0, 0, 0, 1, 0);
      tick(2);
      checks++; if (p2_x !== 10'd558 || p1_state !== 2'd0) begin errors++; $display("FAIL hit_setup: got x=%0d st=%0d expected 558/0", p2_x, p1_state); end
      btn(0, 0, 1, 0, 0, 0);
      tick(1);
      btn(0, 0, 0, 0, 0, 0);
      checks++; if (p1_state !== 2'd2 || p2_state !== 2'd3) begin errors++; $display("FAIL hit_state: got %0d/%0d expected 2/3", p1_state, p2_state); end
      checks++; if (p2_health !== 4'd9 || p1_health !== 4'd10) begin errors++; $display("FAIL hit_health: got %0d/%0d expected 10/9", p1_health, p2_health); end
      checks++; if (int'(p2_x) !== 558 + KB) begin errors++; $display("FAIL hit_p2_x: got %0d expected %0d", p2_x, 558 + KB); end
      tick(7);
      checks++; if (p1_state !== 2'd2) begin errors++; $display("FAIL attack_last: got %0d expected 2", p1_state); end
      tick(1);
      checks++; if (p1_state !== 2'd0 || p2_state !== 2'd3) begin errors++; $display("FAIL attack_end: got %0d/%0d expected 0/3", p1_state, p2_state); end
      // New attack while P2 is still in HIT: no re-hit, P2 buttons ignored.
      btn(0, 0, 1, 1, 0, 0);
      tick(1);
      btn(0, 0, 0, 0, 0, 0);
      checks++; if (p1_state !== 2'd2 || p2_health !== 4'd9) begin errors++; $display("FAIL no_rehit: got st=%0d hp=%0d expected 2/9", p1_state, p2_health); end
      checks++; if (int'(p2_x) !== 558 + KB) begin errors++; $display("FAIL hit_ignores_btn: got %0d expected %0d", p2_x, 558 + KB); end
      tick(6);
      checks++; if (p2_state !== 2'd3) begin errors++; $display("FAIL hit_last: got %0d expected 3", p2_state); end
      tick(1);
      checks++; if (p2_state !== 2'd0 || p1_state !== 2'd2) begin errors++; $display("FAIL hit_end: got %0d/%0d expected 2/0", p1_state, p2_state); end
      tick(1);
      checks++; if (p1_state !== 2'd0) begin errors++; $display("FAIL attack2_end: got %0d expected 0", p1_state); end
   endtask

   task automatic test_mutual();
      approach();
      checks++; if (p1_x !== 10'd260 || p2_x !== 10'd330) begin errors++; $display("FAIL approach: got %0d/%0d expected 260/330", p1_x, p2_x); end
      btn(0, 0, 1, 0, 0, 1);
      tick(1);
      btn(0, 0, 0, 0, 0, 0);
      checks++; if (p1_state !== 2'd3 || p2_state !== 2'd3) begin errors++; $display("FAIL mutual_state: got %0d/%0d expected 3/3", p1_state, p2_state); end
      checks++; if (p1_health !== 4'd9 || p2_health !== 4'd9) begin errors++; $display("FAIL mutual_health: got %0d/%0d expected 9/9", p1_health, p2_health); end
      checks++; if (int'(p1_x) !== 260 - KB || int'(p2_x) !== 330 + KB) begin errors++; $display("FAIL mutual_x: got %0d/%0d expected %0d/%0d", p1_x, p2_x, 260 - KB, 330 + KB); end
   endtask

   task automatic test_game_over();
      approach();
      for (int i = 1; i <= 10; i++) begin
         btn(0, 0, 1, 0, 0, 0);
         tick(1);
         btn(0, 0, 0, 0, 0, 0);
         checks++; if (int'(p2_health) !== 10 - i) begin errors++; $display("FAIL hp_step%0d: got %0d expected %0d", i, p2_health, 10 - i); end
         if (i < 10) begin
            tick(16);
            btn(0, 0, 0, 1, 0, 0);
            tick(4);
            btn(0, 0, 0, 0, 0, 0);
         end
         if (i == 9) begin
            checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL early_over: got %0d expected 0", game_over); end
         end
      end
      checks++; if (game_over !== 1'b1 || winner !== 2'b01) begin errors++; $display("FAIL over_p1: got %0d/%0d expected 1/1", game_over, winner); end
      checks++; if (p2_state !== 2'd3 || p1_state !== 2'd2) begin errors++; $display("FAIL over_state: got %0d/%0d expected 2/3", p1_state, p2_state); end
      // Frozen: further frames with buttons change nothing.
      btn(0, 1, 0, 1, 0, 1);
      tick(20);
      btn(0, 0, 0, 0, 0, 0);
      checks++; if (p1_x !== 10'd260 || int'(p2_x) !== (KB != 0 ? 346 : 310)) begin errors++; $display("FAIL frozen_x: got %0d/%0d expected 260/%0d", p1_x, p2_x, (KB != 0 ? 346 : 310)); end
      checks++; if (p1_state !== 2'd2 || p2_state !== 2'd3 || p2_health !== 4'd0 || p1_health !== 4'd10) begin errors++; $display("FAIL frozen_state: got st=%0d/%0d hp=%0d/%0d expected 2/3 10/0", p1_state, p2_state, p1_health, p2_health); end
      checks++; if (game_over !== 1'b1 || winner !== 2'b01) begin errors++; $display("FAIL frozen_over: got %0d/%0d expected 1/1", game_over, winner); end
      do_reset();
      checks++; if (p1_x !== 10'd20 || p2_x !== 10'd570 || p1_health !== 4'd10 || p2_health !== 4'd10) begin errors++; $display("FAIL restart: got x=%0d/%0d hp=%0d/%0d expected 20/570 10/10", p1_x, p2_x, p1_health, p2_health); end
      checks++; if (game_over !== 1'b0 || winner !== 2'b00 || p1_state !== 2'd0 || p2_state !== 2'd0) begin errors++; $display("FAIL restart_over: got %0d/%0d expected 0/0", game_over, winner); end
   endtask

   task automatic test_draw();
      approach();
      for (int i = 1; i <= 10; i++) begin
         btn(0, 0, 1, 0, 0, 1);
         tick(1);
         btn(0, 0, 0, 0, 0, 0);
         if (i < 10) begin
            tick(16);
            btn(0, 1, 0, 1, 0, 0);
            tick(4);
            btn(0, 0, 0, 0, 0, 0);
         end
      end
      checks++; if (p1_health !== 4'd0 || p2_health !== 4'd0) begin errors++; $display("FAIL draw_health: got %0d/%0d expected 0/0", p1_health, p2_health); end
      checks++; if (game_over !== 1'b1 || winner !== 2'b11) begin errors++; $display("FAIL draw_winner: got %0d/%0d expected 1/3", game_over, winner); end
   endtask

   initial begin
      rst = 1'b1;
      frame_tick = 1'b0;
      btn(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_move_right();
      test_clamp_left();
      test_block();
      test_hit();
      test_mutual();
      test_game_over();
      test_draw();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
